ps2_keyb: RTL and testbench
===========================

Name: ps2_keyb

Overview:
- Converts a PS/2 keyboard (scan code set 2) into the 8x5 ZX Spectrum key matrix.
- Drives the ULA `kbd` column inputs, which are currently tied to 5'b11111.
- The ULA places the CPU high address byte on `rows`; the block returns the active-low column state of all selected rows.
- Runs on the 28 MHz system clock. Samples the asynchronous PS/2 lines internally.

Parameters:
- FILTER_LEN, 8: consecutive equal samples needed before the filtered ps2clk changes level.
- TIMEOUT_CYCLES, 5600: clk cycles (200 us at 28 MHz) without a falling ps2clk edge before a partial frame is abandoned.

Ports:
- clk  in  1  28 MHz system clock
- rst  in  1  synchronous active-high reset
- ps2clk  in  1  raw PS/2 clock, asynchronous
- ps2data  in  1  raw PS/2 data, asynchronous
- rows  in  8  row select, active low (CPU A15..A8)
- kbd  out  5  column data, active low, bit0..bit4
- scan_valid  out  1  one-cycle strobe: valid byte received
- scancode  out  8  last valid byte received

Behaviour:
- Reset values:
  - all 40 matrix bits = 1 (released); `kbd` = 5'b11111; `scan_valid` = 0; `scancode` = 8'h00
  - receiver in IDLE; extended and release prefix flags cleared
- Input conditioning:
  - 2-FF synchronizer on both PS/2 lines.
  - ps2clk passes a FILTER_LEN shift filter; the filtered level toggles only when all samples agree.
  - A falling edge of filtered ps2clk produces one-cycle `fall`.
- Receiver FSM, one data sample per `fall`:
  - IDLE: on `fall` with data=0 -> DATA, bitcnt=0. A `fall` with data=1 stays in IDLE.
  - DATA: shift in LSB first; after 8 bits -> PARITY.
  - PARITY: latch bit -> STOP.
  - STOP: require data=1 and odd parity over data+parity.
    - On success: `scancode` <= byte, `scan_valid` = 1 for one cycle.
    - Always -> IDLE.
  - Parity or stop error: byte discarded; prefix flags cleared; no strobe.
  - Timeout: counter cleared on every `fall`. Reaching TIMEOUT_CYCLES in any state other than IDLE -> IDLE, prefix flags cleared.
- Decoder, acts in the cycle after `scan_valid`:
  - E0: set ext flag.
  - F0: set rel flag.
  - Any other byte:
    - look up mapped key(s); write matrix bit(s) = rel (1 = released, 0 = pressed)
    - then clear both flags
  - Unmapped codes: ignored, flags still cleared.
  - AA (BAT OK) and codes arriving with rst asserted: no matrix change.
- Matrix map (row: bit0..bit4):
  - row0 CS Z X C V
  - row1 A S D F G
  - row2 Q W E R T
  - row3 1 2 3 4 5
  - row4 0 9 8 7 6
  - row5 P O I U Y
  - row6 ENTER L K J H
  - row7 SPACE SS M N B
- Set-2 codes:
  - CS=12 (LShift); SS=59 (RShift) and 14 (LCtrl, non-extended)
  - Z=1A X=22 C=21 V=2A
  - A=1C S=1B D=23 F=2B G=34
  - Q=15 W=1D E=24 R=2D T=2C
  - 1=16 2=1E 3=26 4=25 5=2E
  - 0=45 9=46 8=3E 7=3D 6=36
  - P=4D O=44 I=43 U=3C Y=35
  - ENTER=5A L=4B K=42 J=3B H=33
  - SPACE=29 M=3A N=31 B=32
- Without the optional feature, ext-flagged bytes other than 14 and 5A are ignored. E0 14 (RCtrl) maps to SS; E0 5A (keypad Enter) maps to ENTER.
- Output:
  - `kbd[i]` registered = AND over r of (matrix[r][i] OR rows[r]).
  - Latency: 1 clk from `rows` or matrix change.
  - rows=8'hFF -> 5'b11111.
  - rows=8'h00 -> AND of all rows.
- Simultaneous events: a matrix write and a `rows` change in the same cycle are both visible in `kbd` the next cycle.
- Reset mid-frame: rst overrides everything; the partial frame is lost.

Optional Feature:
- Macro: PS2_KEYB_CURSOR_EN.
- Defined:
  - E0 6B/E0 74/E0 75/E0 72 (Left/Right/Up/Down) set or clear CS together with 5/8/7/6.
  - Non-extended 66 (Backspace) maps to CS+0.
  - The shared CS bit is released when either physical source releases. No reference counting.
- Undefined: those codes are ignored. Logic absent.

Test Plan:
- Reset, then send frame 1C (A), rows=8'hFD -> `scan_valid` pulse with `scancode`=1C; `kbd`=5'b11110. Send F0 1C -> `kbd`=5'b11111.
- Press 12 and 1A, rows=8'hFE -> `kbd`=5'b11100. rows=8'hFF -> 5'b11111. rows=8'h00 -> 5'b11100.
- Frame 29 with bad parity -> no strobe, matrix unchanged; `kbd`=5'b11111 for rows=8'h7F.
- Send 4 bits of a frame, idle 5600 cycles, then a full 16 (1) frame -> strobe with `scancode`=16; rows=8'hF7 gives `kbd`=5'b11110.
- ps2clk glitch of 3 clk cycles low mid-frame -> ignored; the following byte decodes correctly.
- PS2_KEYB_CURSOR_EN defined: E0 75, rows=8'hEE -> `kbd`=5'b10110 (CS row0 bit0, 7 row4 bit3). E0 F0 75 -> 5'b11111. Undefined: same stimulus -> 5'b11111.

Source files
------------

// File: rtl/ps2_keyb.sv
// PS/2 set-2 keyboard to ZX Spectrum 8x5 key matrix, driving the ULA column inputs.
// Optional cursor/backspace mapping is enabled by defining PS2_KEYB_CURSOR_EN.
module ps2_keyb #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 5600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk,
  input  logic       ps2data,
  input  logic [7:0] rows,
  output logic [4:0] kbd,
  output logic       scan_valid,
  output logic [7:0] scancode
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]            r_clk_sync;
  logic [1:0]            r_data_sync;
  logic [FILTER_LEN-1:0] r_clk_hist;
  logic                  r_clk_filt;
  logic                  w_fall;
  logic                  w_data;

  state_t                r_state;
  logic [2:0]            r_bitcnt;
  logic [7:0]            r_shift;
  logic                  r_parity;
  logic [TW-1:0]         r_to_cnt;
  logic                  r_scan_valid;
  logic [7:0]            r_scancode;
  logic                  r_flag_clr;

  logic                  r_ext;
  logic                  r_rel;
  logic [39:0]           r_matrix;
  logic [6:0]            w_map;
  logic                  w_cs_hit;
  logic [4:0]            w_kbd;
  logic [4:0]            r_kbd;

  assign w_data = r_data_sync[1];
  // Filtered clock is still high while the history has gone all-low: exactly one cycle.
  assign w_fall = r_clk_filt && (r_clk_hist == '0);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_hist  <= '1;
      r_clk_filt  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2clk};
      r_data_sync <= {r_data_sync[0], ps2data};
      r_clk_hist  <= {r_clk_hist[FILTER_LEN-2:0], r_clk_sync[1]};
      if (r_clk_hist == '1)      r_clk_filt <= 1'b1;
      else if (r_clk_hist == '0) r_clk_filt <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_to_cnt     <= '0;
      r_scan_valid <= 1'b0;
      r_scancode   <= 8'h00;
      r_flag_clr   <= 1'b0;
    end else begin
      r_scan_valid <= 1'b0;
      r_flag_clr   <= 1'b0;
      if (r_state == S_IDLE || w_fall) r_to_cnt <= '0;
      else                             r_to_cnt <= r_to_cnt + TW'(1);

      if (r_state != S_IDLE && !w_fall && r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        r_state    <= S_IDLE;
        r_flag_clr <= 1'b1;
      end else if (w_fall) begin
        case (r_state)
          S_IDLE: if (!w_data) begin
            r_state  <= S_DATA;
            r_bitcnt <= '0;
          end
          S_DATA: begin
            r_shift  <= {w_data, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_parity <= w_data;
            r_state  <= S_STOP;
          end
          S_STOP: begin
            if (w_data && (^{r_shift, r_parity})) begin
              r_scancode   <= r_shift;
              r_scan_valid <= 1'b1;
            end else begin
              r_flag_clr <= 1'b1;
            end
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Key lookup: w_map = {hit, matrix index row*5+bit}; w_cs_hit adds Caps Shift.
  always_comb begin
    w_map    = '0;
    w_cs_hit = 1'b0;
    if (!r_ext) begin
      case (r_scancode)
        8'h12: w_map = {1'b1, 6'd0};   8'h1A: w_map = {1'b1, 6'd1};
        8'h22: w_map = {1'b1, 6'd2};   8'h21: w_map = {1'b1, 6'd3};
        8'h2A: w_map = {1'b1, 6'd4};   8'h1C: w_map = {1'b1, 6'd5};
        8'h1B: w_map = {1'b1, 6'd6};   8'h23: w_map = {1'b1, 6'd7};
        8'h2B: w_map = {1'b1, 6'd8};   8'h34: w_map = {1'b1, 6'd9};
        8'h15: w_map = {1'b1, 6'd10};  8'h1D: w_map = {1'b1, 6'd11};
        8'h24: w_map = {1'b1, 6'd12};  8'h2D: w_map = {1'b1, 6'd13};
        8'h2C: w_map = {1'b1, 6'd14};  8'h16: w_map = {1'b1, 6'd15};
        8'h1E: w_map = {1'b1, 6'd16};  8'h26: w_map = {1'b1, 6'd17};
        8'h25: w_map = {1'b1, 6'd18};  8'h2E: w_map = {1'b1, 6'd19};
        8'h45: w_map = {1'b1, 6'd20};  8'h46: w_map = {1'b1, 6'd21};
        8'h3E: w_map = {1'b1, 6'd22};  8'h3D: w_map = {1'b1, 6'd23};
        8'h36: w_map = {1'b1, 6'd24};  8'h4D: w_map = {1'b1, 6'd25};
        8'h44: w_map = {1'b1, 6'd26};  8'h43: w_map = {1'b1, 6'd27};
        8'h3C: w_map = {1'b1, 6'd28};  8'h35: w_map = {1'b1, 6'd29};
        8'h5A: w_map = {1'b1, 6'd30};  8'h4B: w_map = {1'b1, 6'd31};
        8'h42: w_map = {1'b1, 6'd32};  8'h3B: w_map = {1'b1, 6'd33};
        8'h33: w_map = {1'b1, 6'd34};  8'h29: w_map = {1'b1, 6'd35};
        8'h59: w_map = {1'b1, 6'd36};  8'h14: w_map = {1'b1, 6'd36};
        8'h3A: w_map = {1'b1, 6'd37};  8'h31: w_map = {1'b1, 6'd38};
        8'h32: w_map = {1'b1, 6'd39};
`ifdef PS2_KEYB_CURSOR_EN
        8'h66: begin w_map = {1'b1, 6'd20}; w_cs_hit = 1'b1; end
`endif
        default: w_map = '0;
      endcase
    end else begin
      case (r_scancode)
        8'h14: w_map = {1'b1, 6'd36};
        8'h5A: w_map = {1'b1, 6'd30};
`ifdef PS2_KEYB_CURSOR_EN
        8'h6B: begin w_map = {1'b1, 6'd19}; w_cs_hit = 1'b1; end
        8'h74: begin w_map = {1'b1, 6'd22}; w_cs_hit = 1'b1; end
        8'h75: begin w_map = {1'b1, 6'd23}; w_cs_hit = 1'b1; end
        8'h72: begin w_map = {1'b1, 6'd24}; w_cs_hit = 1'b1; end
`endif
        default: w_map = '0;
      endcase
    end
  end

  // NOTE: the 40-bit matrix is plain flops, so it is reset to "all released" like any register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_matrix <= '1;
      r_ext    <= 1'b0;
      r_rel    <= 1'b0;
    end else if (r_flag_clr) begin
      r_ext <= 1'b0;
      r_rel <= 1'b0;
    end else if (r_scan_valid) begin
      if (r_scancode == 8'hE0) begin
        r_ext <= 1'b1;
      end else if (r_scancode == 8'hF0) begin
        r_rel <= 1'b1;
      end else begin
        if (w_map[6]) r_matrix[w_map[5:0]] <= r_rel;
        if (w_cs_hit) r_matrix[0]          <= r_rel;
        r_ext <= 1'b0;
        r_rel <= 1'b0;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_kbd = '1;
    for (int r = 0; r < 8; r++)
      for (int i = 0; i < 5; i++)
        w_kbd[i] = w_kbd[i] & (r_matrix[r*5+i] | rows[r]);
  end

  always_ff @(posedge clk) begin
    if (rst) r_kbd <= '1;
    else     r_kbd <= w_kbd;
  end

  assign kbd        = r_kbd;
  assign scan_valid = r_scan_valid;
  assign scancode   = r_scancode;

endmodule

// File: tb/tb_ps2_keyb.sv
// Directed bench for ps2_keyb: PS/2 frames in, scancode scoreboard and kbd matrix checks.
module tb_ps2_keyb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2clk = 1'b1;
  logic       ps2data = 1'b1;
  logic [7:0] rows = 8'hFF;
  logic [4:0] kbd;
  logic       scan_valid;
  logic [7:0] scancode;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];

  ps2_keyb dut (
    .clk        (clk),
    .rst        (rst),
    .ps2clk     (ps2clk),
    .ps2data    (ps2data),
    .rows       (rows),
    .kbd        (kbd),
    .scan_valid (scan_valid),
    .scancode   (scancode)
  );

  always #5 clk = ~clk;

  // Scoreboard: every strobe must match the oldest expected byte.
  always @(negedge clk) begin
    if (scan_valid) begin
      logic [7:0] exp_b;
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_errors++;
        $error("FAIL unexpected_strobe scancode=%h expected=none", scancode);
      end
      if (exp_q.size() != 0) begin
        exp_b = exp_q.pop_front();
        n_checks++;
        assert (scancode === exp_b) else begin
          n_errors++;
          $error("FAIL scancode got=%h exp=%h", scancode, exp_b);
        end
      end
    end
  end

  task automatic ps2_bit(input logic v, input bit glitch);
    ps2data = v;
    repeat (10) @(negedge clk);
    if (glitch) begin
      ps2clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2clk = 1'b1;
    end
    repeat (10) @(negedge clk);
    ps2clk = 1'b0;
    repeat (40) @(negedge clk);
    ps2clk = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_errors++;
      $error("FAIL drain_%s pending=%0d exp=0", tag, exp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit glitch);
    logic par;
    par = (~^b) ^ bad_par;
    if (!bad_par) exp_q.push_back(b);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch && (i == 4));
    ps2_bit(par, 1'b0);
    ps2_bit(1'b1, 1'b0);
    if (bad_par) repeat (100) @(negedge clk);
    else         wait_drain($sformatf("%h", b));
  endtask

  task automatic check_kbd(input logic [7:0] r, input logic [4:0] exp, input string tag);
    rows = r;
    repeat (3) @(negedge clk);
    n_checks++;
    assert (kbd === exp) else begin
      n_errors++;
      $error("FAIL kbd_%s got=%b exp=%b", tag, kbd, exp);
    end
  endtask

  initial begin
    logic [4:0] cur_exp;
`ifdef PS2_KEYB_CURSOR_EN
    cur_exp = 5'b10110;
`else
    cur_exp = 5'b11111;
`endif
    rows = 8'h00;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    assert (scancode === 8'h00 && scan_valid === 1'b0) else begin
      n_errors++;
      $error("FAIL reset_out scancode=%h valid=%b exp=00/0", scancode, scan_valid);
    end
    check_kbd(8'h00, 5'b11111, "reset");

    // A press then release
    send_byte(8'h1C, 0, 0);
    check_kbd(8'hFD, 5'b11110, "a_press");
    send_byte(8'hF0, 0, 0);
    send_byte(8'h1C, 0, 0);
    check_kbd(8'hFD, 5'b11111, "a_release");

    // CS + Z held, row select variations
    send_byte(8'h12, 0, 0);
    send_byte(8'h1A, 0, 0);
    check_kbd(8'hFE, 5'b11100, "csz_row0");
    check_kbd(8'hFF, 5'b11111, "csz_none");
    check_kbd(8'h00, 5'b11100, "csz_all");
    send_byte(8'hF0, 0, 0);
    send_byte(8'h12, 0, 0);
    send_byte(8'hF0, 0, 0);
    send_byte(8'h1A, 0, 0);
    check_kbd(8'h00, 5'b11111, "csz_release");

    // Bad parity: no strobe, matrix and scancode unchanged
    send_byte(8'h29, 1, 0);
    check_kbd(8'h7F, 5'b11111, "bad_parity");
    n_checks++;
    assert (scancode === 8'h1A) else begin
      n_errors++;
      $error("FAIL bad_parity_scancode got=%h exp=1A", scancode);
    end

    // Partial frame abandoned by timeout
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
    repeat (6000) @(negedge clk);
    send_byte(8'h16, 0, 0);
    check_kbd(8'hF7, 5'b11110, "timeout_1");
    send_byte(8'hF0, 0, 0);
    send_byte(8'h16, 0, 0);

    // Short ps2clk glitch mid-frame
    send_byte(8'h2A, 0, 1);
    check_kbd(8'hFE, 5'b01111, "glitch_v");
    send_byte(8'hF0, 0, 0);
    send_byte(8'h2A, 0, 0);
    check_kbd(8'hFE, 5'b11111, "v_release");

    // Extended keys: keypad Enter mapped, E0 1C ignored
    send_byte(8'hE0, 0, 0);
    send_byte(8'h5A, 0, 0);
    check_kbd(8'hBF, 5'b11110, "kp_enter");
    send_byte(8'hE0, 0, 0);
    send_byte(8'hF0, 0, 0);
    send_byte(8'h5A, 0, 0);
    send_byte(8'hE0, 0, 0);
    send_byte(8'h1C, 0, 0);
    check_kbd(8'h00, 5'b11111, "ext_unmapped");

    // Cursor Up
    send_byte(8'hE0, 0, 0);
    send_byte(8'h75, 0, 0);
    check_kbd(8'hEE, cur_exp, "cursor_up");
    send_byte(8'hE0, 0, 0);
    send_byte(8'hF0, 0, 0);
    send_byte(8'h75, 0, 0);
    check_kbd(8'hEE, 5'b11111, "cursor_release");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
